sub_share_arb: RTL and testbench



---
 rtl/sub_share_arb_if.sv | 26 ++
 rtl/sub_share_arb.sv | 134 +++++++++++++
 tb/tb_sub_share_arb.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sub_share_arb_if.sv
// Handshake/bus bundle between the requesters, the sub_share_arb scheduler and the shared sub unit.
interface sub_share_arb_if #(
  parameter int unsigned NREQ = 4
);
  logic            hold;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_a;
  logic [NREQ-1:0] req_b;
  logic [NREQ-1:0] req_ready;
  logic            sub_valid;
  logic            sub_a;
  logic            sub_b;
  logic            sub_c;
  logic [NREQ-1:0] rsp_valid;
  logic            rsp_c;

  modport master (
    output hold, req_valid, req_a, req_b, sub_c,
    input  req_ready, sub_valid, sub_a, sub_b, rsp_valid, rsp_c
  );

  modport slave (
    input  hold, req_valid, req_a, req_b, sub_c,
    output req_ready, sub_valid, sub_a, sub_b, rsp_valid, rsp_c
  );
endinterface

// File: rtl/sub_share_arb.sv
// Round-robin scheduler sharing one single-bit sub unit among NREQ requesters, with credit limits.
// Optional: define SUB_SHARE_ARB_PRIO0_EN to give requester 0 absolute priority.
module sub_share_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LAT     = 2,
  parameter int unsigned MAX_OUT = 2
) (
  input logic            clk,
  input logic            rst,
  sub_share_arb_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] idx;
  } tag_t;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win;
  logic [IW-1:0]   jj;
  logic            accept;
  logic [IW-1:0]   ptr;
  logic [2:0]      cnt [NREQ];
  logic            sub_valid_q;
  logic            sub_a_q;
  logic            sub_b_q;
  logic [IW-1:0]   iss_idx;
  tag_t            pipe [LAT];
  tag_t            head;
  logic [NREQ-1:0] rsp_valid_q;
  logic            rsp_c_q;

  // Eligibility: valid, credit available, not held, not in reset
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = !rst && !bus.hold && bus.req_valid[i] && (cnt[i] < 3'(MAX_OUT));
    end
  end

  // First eligible requester from ptr upward, wrapping; optional requester-0 override
  always_comb begin
    grant  = '0;
    win    = '0;
    accept = 1'b0;
    jj     = '0;
`ifdef SUB_SHARE_ARB_PRIO0_EN
    if (elig[0]) begin
      grant[0] = 1'b1;
      accept   = 1'b1;
    end
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
      jj = (32'(ptr) + k >= NREQ) ? IW'(32'(ptr) + k - NREQ) : IW'(32'(ptr) + k);
      if (!accept && elig[jj]) begin
        grant[jj] = 1'b1;
        win       = jj;
        accept    = 1'b1;
      end
    end
  end

  // Issue register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      sub_valid_q <= 1'b0;
      sub_a_q     <= 1'b0;
      sub_b_q     <= 1'b0;
      iss_idx     <= '0;
    end else begin
      sub_valid_q <= accept;
      if (accept) begin
        sub_a_q <= bus.req_a[win];
        sub_b_q <= bus.req_b[win];
        iss_idx <= win;
      end
`ifdef SUB_SHARE_ARB_PRIO0_EN
      if (accept && !grant[0]) begin
`else
      if (accept) begin
`endif
        ptr <= (win == IW'(NREQ - 1)) ? '0 : IW'(win + 1'b1);
      end
    end
  end

  // Tag pipeline; the head lines up with sub_c
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{v: sub_valid_q, idx: iss_idx};
      for (int unsigned k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign head = pipe[LAT-1];

  // Registered response routing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_c_q     <= 1'b0;
    end else begin
      rsp_valid_q <= head.v ? (NREQ'(1) << head.idx) : '0;
      if (head.v) rsp_c_q <= bus.sub_c;
    end
  end

  // Credit counters: accept adds, response returns, both together cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i] && !rsp_valid_q[i] && (cnt[i] < 3'(MAX_OUT))) begin
          cnt[i] <= cnt[i] + 3'd1;
        end else if (rsp_valid_q[i] && !grant[i] && (cnt[i] != 3'd0)) begin
          cnt[i] <= cnt[i] - 3'd1;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.sub_valid = sub_valid_q;
  assign bus.sub_a     = sub_a_q;
  assign bus.sub_b     = sub_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_c     = rsp_c_q;
endmodule

// File: tb/tb_sub_share_arb.sv
// Directed bench for sub_share_arb (NREQ=4, LAT=2, MAX_OUT=2) with a behavioural sub unit (c = a ^ b).
module tb_sub_share_arb;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned LAT     = 2;
  localparam int unsigned MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sub_share_arb_if #(.NREQ(NREQ)) bus ();

  sub_share_arb #(.NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared unit model: one-bit difference, LAT cycles after issue
  logic [LAT-1:0] dq = '0;
  always @(posedge clk) dq <= {dq[LAT-2:0], bus.sub_a ^ bus.sub_b};
  assign bus.sub_c = dq[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [3:0]  e;
  logic [3:0]  x;
  logic [15:0] rdy_pat;
  logic [15:0] rsp_pat;
  logic [7:0]  prio_pat [8];

  initial begin
    bus.hold      = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_sub_valid", 32'(bus.sub_valid), 32'h0);
    chk("rst_sub_ab", 32'({bus.sub_a, bus.sub_b}), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_c", 32'(bus.rsp_c), 32'h0);
    nxt();
    nxt();
    rst           = 1'b0;
    bus.req_valid = '0;

    // Single op from requester 2
    bus.req_valid = 4'b0100;
    bus.req_a     = 4'b0100;
    bus.req_b     = 4'b0000;
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'h4);
    chk("t1_sv_T", 32'(bus.sub_valid), 32'h0);
    nxt();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_sv_T1", 32'(bus.sub_valid), 32'h1);
    chk("t1_ab", 32'({bus.sub_a, bus.sub_b}), 32'h2);
    chk("t1_ready_idle", 32'(bus.req_ready), 32'h0);
    nxt();
    @(negedge clk);
    chk("t1_rsp_T2", 32'(bus.rsp_valid), 32'h0);
    nxt();
    @(negedge clk);
    chk("t1_rsp_T3", 32'(bus.rsp_valid), 32'h0);
    nxt();
    @(negedge clk);
    chk("t1_rsp_T4", 32'(bus.rsp_valid), 32'h4);
    chk("t1_rspc_T4", 32'(bus.rsp_c), 32'h1);
    nxt();
    @(negedge clk);
    chk("t1_rsp_T5", 32'(bus.rsp_valid), 32'h0);
    chk("t1_rspc_hold", 32'(bus.rsp_c), 32'h1);
    nxt();

    // Reset pulsed one cycle after an issue (ptr was 3 here)
    bus.req_valid = 4'b0001;
    bus.req_a     = 4'b0001;
    bus.req_b     = 4'b0001;
    @(negedge clk);
    chk("t2_ready", 32'(bus.req_ready), 32'h1);
    nxt();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t2_sv", 32'(bus.sub_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("t2_rst_sv", 32'(bus.sub_valid), 32'h0);
    chk("t2_rst_ab", 32'({bus.sub_a, bus.sub_b}), 32'h0);
    chk("t2_rst_rspc", 32'(bus.rsp_c), 32'h0);
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_no_rsp", 32'(bus.rsp_valid), 32'h0);
      nxt();
    end
    // ptr back at 0; valid dropped before the edge leaves state untouched
    for (int k = 0; k < 2; k++) begin
      bus.req_valid = 4'b0011;
      @(negedge clk);
      chk("t2_ptr0", 32'(bus.req_ready), 32'h1);
      bus.req_valid = '0;
      nxt();
    end

`ifndef SUB_SHARE_ARB_PRIO0_EN
    // All four requesters streaming: grant 0,1,2,3,... with responses looping back
    bus.req_a = 4'b1010;
    bus.req_b = 4'b0110;
    x         = 4'b1100;
    for (int k = 0; k < 16; k++) begin
      bus.req_valid = (k < 12) ? 4'hF : 4'h0;
      @(negedge clk);
      e = (k < 12) ? (4'(1) << (k % 4)) : 4'h0;
      chk("rr_ready", 32'(bus.req_ready), 32'(e));
      chk("rr_sv", 32'(bus.sub_valid), (k >= 1 && k <= 12) ? 32'h1 : 32'h0);
      if (k >= 1 && k <= 12) chk("rr_sub_a", 32'(bus.sub_a), 32'(bus.req_a[(k - 1) % 4]));
      e = (k >= 4) ? (4'(1) << ((k - 4) % 4)) : 4'h0;
      chk("rr_rsp", 32'(bus.rsp_valid), 32'(e));
      if (k >= 4) chk("rr_rsp_c", 32'(bus.rsp_c), 32'(x[(k - 4) % 4]));
      nxt();
    end
`endif

    // Credit stall: requester 1 alone
    rdy_pat = 16'h0463;
    rsp_pat = 16'h4630;
    for (int k = 0; k < 16; k++) begin
      bus.req_valid = (k <= 10) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      chk("cr_ready", 32'(bus.req_ready), rdy_pat[k] ? 32'h2 : 32'h0);
      chk("cr_rsp", 32'(bus.rsp_valid), rsp_pat[k] ? 32'h2 : 32'h0);
      nxt();
    end

    // Hold with two operations in flight (ptr is 2 here)
    bus.req_valid = 4'b0100;
    bus.req_a     = 4'b0100;
    bus.req_b     = 4'b0000;
    @(negedge clk);
    chk("h_ready0", 32'(bus.req_ready), 32'h4);
    nxt();
    bus.req_valid = 4'b0001;
    bus.req_a     = 4'b0001;
    bus.req_b     = 4'b0001;
    @(negedge clk);
    chk("h_ready1", 32'(bus.req_ready), 32'h1);
    chk("h_sv1", 32'(bus.sub_valid), 32'h1);
    nxt();
    bus.hold      = 1'b1;
    bus.req_valid = 4'hF;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("h_ready_hold", 32'(bus.req_ready), 32'h0);
      chk("h_sv_hold", 32'(bus.sub_valid), (k == 2) ? 32'h1 : 32'h0);
      if (k == 3) chk("h_ab_held", 32'({bus.sub_a, bus.sub_b}), 32'h3);
      chk("h_rsp", 32'(bus.rsp_valid), (k == 4) ? 32'h4 : 32'h0);
      if (k == 4) chk("h_rsp_c2", 32'(bus.rsp_c), 32'h1);
      nxt();
    end
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("h_sv5", 32'(bus.sub_valid), 32'h0);
    chk("h_rsp5", 32'(bus.rsp_valid), 32'h1);
    chk("h_rsp_c0", 32'(bus.rsp_c), 32'h0);
    nxt();
    @(negedge clk);
    chk("h_rsp6", 32'(bus.rsp_valid), 32'h0);
    nxt();

`ifdef SUB_SHARE_ARB_PRIO0_EN
    // Requester 0 priority over 3 until its credits run out
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    prio_pat = '{8'h1, 8'h1, 8'h8, 8'h8, 8'h0, 8'h1, 8'h1, 8'h8};
    for (int k = 0; k < 8; k++) begin
      bus.req_valid = 4'b1001;
      @(negedge clk);
      chk("p0_ready", 32'(bus.req_ready), 32'(prio_pat[k]));
      nxt();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) nxt();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
